// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the parametrised mux family: select-mode encodings,
// output-slot states and the width helper used to size select/pointer fields.
package mux_nx1_rr_pkg;

    localparam logic MODE_DIRECT      = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Bits needed to hold an index 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/mux_nx1_rr_pick.sv
// Rotate-priority search: first asserted request at or after i_ptr, wrapping
// modulo N. Purely combinational so other arbiters can reuse it.
module mux_nx1_rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic          o_grant_valid,
    output logic [SW-1:0] o_grant_idx
);

    logic [SW-1:0] w_idx;

    // Walk from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = SW'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// Registered N-to-1 channel merger with valid/ready handshakes; selects either
// an externally chosen channel or scans valid channels round-robin.
//
//   state      | meaning
//   SLOT_EMPTY | output register holds no unconsumed word (o_out_valid=0)
//   SLOT_FULL  | output register holds a word waiting for i_out_ready
module mux_nx1_rr
    import mux_nx1_rr_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 1,
    localparam int SW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] i_in_data,
    input  logic [N-1:0]   i_in_valid,
    output logic [N-1:0]   o_in_ready,
    input  logic           i_mode,
    input  logic [SW-1:0]  i_sel,
    output logic [W-1:0]   o_out_data,
    output logic [SW-1:0]  o_out_sel,
    output logic           o_out_valid,
    input  logic           i_out_ready
);

    slot_e         r_slot;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_ptr;

    logic [W-1:0]  w_chan [N];
    logic          w_rr_valid;
    logic [SW-1:0] w_rr_idx;
    logic          w_dir_valid;
    logic          w_grant_valid;
    logic [SW-1:0] w_grant_idx;
    logic          w_load_en;
    logic          w_load;
    logic [SW-1:0] w_ptr_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign w_chan[gi]     = i_in_data[gi*W +: W];
        assign o_in_ready[gi] = w_load & (w_grant_idx == SW'(gi));
    end

    mux_nx1_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .i_req         (i_in_valid),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_rr_valid),
        .o_grant_idx   (w_rr_idx)
    );

    // Out-of-range selects (possible when N is not a power of two) never grant.
    assign w_dir_valid = (int'(i_sel) < N) && i_in_valid[i_sel];

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        if (i_mode == MODE_ROUND_ROBIN) begin
            w_grant_valid = w_rr_valid;
            w_grant_idx   = w_rr_idx;
        end else begin
            w_grant_valid = w_dir_valid;
            w_grant_idx   = i_sel;
        end
    end

    assign w_load_en  = (r_slot == SLOT_EMPTY) | i_out_ready;
    assign w_load     = w_load_en & w_grant_valid;
    assign w_ptr_next = (w_grant_idx == SW'(N - 1)) ? '0 : w_grant_idx + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= SLOT_EMPTY;
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else begin
            case (r_slot)
                SLOT_EMPTY: begin
                    if (w_load) begin
                        r_slot <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (i_out_ready && !w_grant_valid) begin
                        r_slot <= SLOT_EMPTY;
                    end
                end
                default: r_slot <= SLOT_EMPTY;
            endcase
            if (w_load) begin
                r_data <= w_chan[w_grant_idx];
                r_sel  <= w_grant_idx;
                if (i_mode == MODE_ROUND_ROBIN) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    assign o_out_data  = r_data;
    assign o_out_sel   = r_sel;
    assign o_out_valid = (r_slot == SLOT_FULL);

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: an N=4 and an N=3 instance checked every cycle against
// a behavioural model, plus directed scenarios with fixed expected values.
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] d4_data = '0;
    logic [3:0]  d4_valid = '0;
    logic [3:0]  d4_ready;
    logic        mode4 = 1'b0;
    logic [1:0]  sel4 = '0;
    logic [3:0]  q4_data;
    logic [1:0]  q4_sel;
    logic        q4_valid;
    logic        ordy4 = 1'b0;

    logic [11:0] d3_data = '0;
    logic [2:0]  d3_valid = '0;
    logic [2:0]  d3_ready;
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [3:0]  q3_data;
    logic [1:0]  q3_sel;
    logic        q3_valid;
    logic        ordy3 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: index 0 is N=4, index 1 is N=3.
    bit m_v [2];
    int m_d [2];
    int m_s [2];
    int m_p [2];

    always #5 clk = ~clk;

    mux_nx1_rr #(.N(4), .W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_data   (d4_data),
        .i_in_valid  (d4_valid),
        .o_in_ready  (d4_ready),
        .i_mode      (mode4),
        .i_sel       (sel4),
        .o_out_data  (q4_data),
        .o_out_sel   (q4_sel),
        .o_out_valid (q4_valid),
        .i_out_ready (ordy4)
    );

    mux_nx1_rr #(.N(3), .W(4)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_data   (d3_data),
        .i_in_valid  (d3_valid),
        .o_in_ready  (d3_ready),
        .i_mode      (mode3),
        .i_sel       (sel3),
        .o_out_data  (q3_data),
        .o_out_sel   (q3_sel),
        .o_out_valid (q3_valid),
        .i_out_ready (ordy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_grant(input int n, input logic mode, input int sel,
                                        input logic [3:0] vld, input int ptr,
                                        output bit gv, output int g);
        int c;
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (sel < n && vld[2'(sel)]) begin
                gv = 1'b1;
                g  = sel;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                c = (ptr + k) % n;
                if (vld[2'(c)]) begin
                    gv = 1'b1;
                    g  = c;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_eval(input int n, input logic mode, input int sel,
                                       input logic [3:0] vld, input logic [15:0] data,
                                       input logic ordy, input bit v, input int d,
                                       input int s, input int p, output logic [3:0] rdy,
                                       output bit nv, output int nd, output int ns,
                                       output int np);
        bit gv;
        int g;
        model_grant(n, mode, sel, vld, p, gv, g);
        rdy = '0;
        nv  = v;
        nd  = d;
        ns  = s;
        np  = p;
        if ((!v || ordy) && gv) begin
            rdy = 4'(1) << g;
            nv  = 1'b1;
            nd  = int'((data >> (4 * g)) & 16'hF);
            ns  = g;
            if (mode) np = (g + 1) % n;
        end else if (v && ordy) begin
            nv = 1'b0;
        end
    endfunction

    // Inputs are set at posedge+1; checks at negedge; model advances at posedge+1.
    task automatic cycle();
        logic [3:0] r4, r3;
        bit nv4, nv3;
        int nd4, nd3, ns4, ns3, np4, np3;
        @(negedge clk);
        model_eval(4, mode4, int'(sel4), d4_valid, d4_data, ordy4,
                   m_v[0], m_d[0], m_s[0], m_p[0], r4, nv4, nd4, ns4, np4);
        model_eval(3, mode3, int'(sel3), {1'b0, d3_valid}, {4'h0, d3_data}, ordy3,
                   m_v[1], m_d[1], m_s[1], m_p[1], r3, nv3, nd3, ns3, np3);
        chk("rdy4", 32'(d4_ready), 32'(r4));
        chk("vld4", 32'(q4_valid), 32'(m_v[0]));
        chk("dat4", 32'(q4_data), m_d[0]);
        chk("sel4", 32'(q4_sel), m_s[0]);
        chk("rdy3", 32'(d3_ready), 32'(r3[2:0]));
        chk("vld3", 32'(q3_valid), 32'(m_v[1]));
        chk("dat3", 32'(q3_data), m_d[1]);
        chk("sel3", 32'(q3_sel), m_s[1]);
        @(posedge clk);
        #1;
        m_v[0] = nv4; m_d[0] = nd4; m_s[0] = ns4; m_p[0] = np4;
        m_v[1] = nv3; m_d[1] = nd3; m_s[1] = ns3; m_p[1] = np3;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld4", 32'(q4_valid), 32'd0);
        chk("rst_dat4", 32'(q4_data), 32'd0);
        chk("rst_sel4", 32'(q4_sel), 32'd0);
        chk("rst_vld3", 32'(q3_valid), 32'd0);
        for (int u = 0; u < 2; u++) begin
            m_v[u] = 1'b0; m_d[u] = 0; m_s[u] = 0; m_p[u] = 0;
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int seq [5];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_v[u] = 1'b0; m_d[u] = 0; m_s[u] = 0; m_p[u] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // DIRECT: channel 2 holds 4'hA
        mode4 = 1'b0; sel4 = 2'd2; d4_data = 16'h4A21; d4_valid = 4'b1111; ordy4 = 1'b1;
        cycle();
        chk("dir_data", 32'(q4_data), 32'hA);
        chk("dir_sel", 32'(q4_sel), 32'd2);
        d4_valid = 4'b1011;
        cycle();
        chk("dir_nogrant_pop", 32'(q4_valid), 32'd0);

        // Round-robin over four always-valid channels
        mode4 = 1'b1; d4_data = 16'h4321; d4_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            seq[i] = int'(q4_sel);
            chk("rr_data", 32'(q4_data), 32'(seq[i] + 1));
        end
        chk("rr_seq0", 32'(seq[0]), 32'd0);
        chk("rr_seq1", 32'(seq[1]), 32'd1);
        chk("rr_seq2", 32'(seq[2]), 32'd2);
        chk("rr_seq3", 32'(seq[3]), 32'd3);
        chk("rr_seq4", 32'(seq[4]), 32'd0);

        // Skip invalid channels starting from ptr=1
        d4_valid = 4'b1001;
        cycle();
        chk("skip_3", 32'(q4_sel), 32'd3);
        cycle();
        chk("skip_0", 32'(q4_sel), 32'd0);

        // Backpressure, then simultaneous pop and load
        d4_valid = 4'b1111; d4_data = 16'h8765; ordy4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_data", 32'(q4_data), 32'h1);
            chk("bp_valid", 32'(q4_valid), 32'd1);
        end
        ordy4 = 1'b1;
        cycle();
        chk("bp_release_valid", 32'(q4_valid), 32'd1);
        chk("bp_release_sel", 32'(q4_sel), 32'd1);
        chk("bp_release_data", 32'(q4_data), 32'h6);

        // Mid-stream reset, then first RR grant must be channel 0
        do_reset();
        cycle();
        chk("post_rst_sel", 32'(q4_sel), 32'd0);
        chk("post_rst_valid", 32'(q4_valid), 32'd1);

        // Non-power-of-two N=3
        d4_valid = 4'b0000;
        mode3 = 1'b1; d3_valid = 3'b111; d3_data = 12'h321; ordy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = int'(q3_sel);
        end
        chk("n3_seq0", 32'(seq[0]), 32'd0);
        chk("n3_seq1", 32'(seq[1]), 32'd1);
        chk("n3_seq2", 32'(seq[2]), 32'd2);
        chk("n3_seq3", 32'(seq[3]), 32'd0);
        mode3 = 1'b0; sel3 = 2'd3;
        #1;
        chk("n3_sel3_ready", 32'(d3_ready), 32'd0);
        cycle();
        chk("n3_sel3_pop", 32'(q3_valid), 32'd0);

        // Randomised traffic on both instances
        for (int i = 0; i < 600; i++) begin
            d4_data  = 16'($urandom);
            d4_valid = 4'($urandom);
            ordy4    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode4 = ~mode4;
            sel4     = 2'($urandom);
            d3_data  = 12'($urandom);
            d3_valid = 3'($urandom);
            ordy3    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode3 = ~mode3;
            sel3     = 2'($urandom);
            if (i == 300) do_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshakes and two selection modes: direct (external select, as in the existing 4x1 dataflow mux) and round-robin scan across valid channels. It is the channel-merging stage placed between multiple producers and a single downstream consumer. It adds an output register, fair arbitration and backpressure, none of which the combinational 4x1 mux provides.

## Interface
- N, 4, number of input channels (≥2, any integer; powers of two not required)
- W, 1, data width per channel
- SW, derived = clog2(N), width of select/pointer fields (not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  channel i has a word pending
- in_ready  out  N  one-hot or zero; bit i high means channel i's word is taken this cycle
- mode  in  1  0 = DIRECT, 1 = ROUND_ROBIN
- sel  in  SW  channel index used in DIRECT mode
- out_data  out  W  registered selected word
- out_sel  out  SW  index of the channel that produced out_data
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data when out_valid is high

## Operation
- Output slot has two states. EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid | out_ready. A load may happen only when load_en is high.
- Grant (combinational, evaluated every cycle):
  - DIRECT: grant channel sel when sel < N and in_valid[sel]. Otherwise there is no grant; sel ≥ N never grants.
  - ROUND_ROBIN: grant the first i with in_valid[i] set, searching ptr, ptr+1, … modulo N. If no channel is valid, there is no grant.
- in_ready[g] = load_en & grant_valid. All other in_ready bits are 0. This output is combinational, so an upstream channel must not make valid depend on ready.
- On load: out_data ← word of channel g, out_sel ← g, out_valid ← 1.
  - In ROUND_ROBIN mode, ptr ← (g+1) mod N. Wrap from N-1 goes to 0, including for non-power-of-two N.
- Pop without load: out_valid & out_ready & no grant → out_valid ← 0. out_data and out_sel hold their last values.
- Simultaneous pop and load: new word replaces old in the same edge and out_valid stays 1.
- ptr is updated only by ROUND_ROBIN grants. DIRECT-mode traffic leaves ptr unchanged, and ptr is kept across mode changes.
- mode and sel are sampled in the same cycle as the grant. A change takes effect on the next load decision and never corrupts a held word.
- FULL with out_ready=0: out_data, out_sel and out_valid are stable, and all in_ready bits are 0.

## Timing
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, ptr=0. Any held word is discarded.
- Latency: a word accepted at edge k (in_ready high in cycle k) is visible on out_data after edge k, and out_valid is high in cycle k+1.
- Throughput: one word per clock when out_ready is held high and some channel is valid.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, the grant sequence is ptr, ptr+1, …, with each channel served exactly once per N cycles.
- No combinational path from in_data to out_data. The only combinational paths are in_valid/mode/sel/out_ready → in_ready.

## Structure
- Shared include mux_defs.vh holds:
  - MODE_DIRECT=1'b0 and MODE_ROUND_ROBIN=1'b1
  - a clog2 constant function shared by all parametrised mux blocks
- Sub-module rr_pick (N, SW):
  - inputs: request vector, start pointer
  - outputs: grant_valid, grant index
  - pure combinational rotate-priority search, which is reused by future arbiters
- Top level holds the grant mux, output register and pointer register.

## Test plan
All scenarios use N=4, W=4.
- Reset: assert rst_n=0 mid-stream while out_valid=1 → out_valid, out_data, out_sel and ptr all read 0 immediately. After release, the first RR grant is channel 0.
- DIRECT: mode=0, sel=2, in_data channel 2 = 4'hA, all valid, out_ready=1 → in_ready=4'b0100, and the next cycle gives out_data=4'hA, out_sel=2. With sel=2 and in_valid=4'b1011 → no grant, and out_valid drops after the pop.
- Round-robin: mode=1, in_valid=4'b1111 held, out_ready=1, data = 1,2,3,4 on channels 0..3 → out_sel sequence 0,1,2,3,0 on consecutive cycles.
- Skip invalid: mode=1, ptr=1, in_valid=4'b1001 → grant 3, then ptr=0, then grant 0.
- Backpressure: FULL with out_ready=0 for 5 cycles and all channels valid → out_data stable, in_ready=0. On out_ready=1 → pop and load occur on the same edge, and out_valid stays 1.
- Non-power-of-two: N=3, mode=1, all valid → out_sel sequence 0,1,2,0. In DIRECT mode, sel=3 → no grant.
